// File: rtl/sitcpxg_rx_pkg.sv
// Shared types and constants for the SiTCP 10GbE receive buffer.
// The SITCPXG_RXBUF_STATS_EN build option lives in sitcpxg_rx_buffer.sv.
package sitcpxg_rx_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned RXSIZE_MARGIN  = 16;

  typedef enum logic [1:0] {
    StRun,
    StClrWait,
    StClrDrain
  } clr_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  bytes;
  } rx_entry_t;

  // Bytes covered from the word start up to and including the lowest enabled lane.
  // WENB bit7 is byte offset 0, so lane i ends at offset 8 - i.
  function automatic logic [3:0] end_offset(input logic [7:0] wenb);
    logic [3:0] off;
    off = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (wenb[i]) off = 4'(BYTES_PER_WORD - i);
    end
    return off;
  endfunction

endpackage

// File: rtl/sitcpxg_rx_bram.sv
// Simple dual-port RAM: 64-bit words, per-byte write enables, registered read.
// Read-during-write to the same word returns the old contents.
module sitcpxg_rx_bram #(
  parameter int unsigned AddrW = 13
) (
  input  logic             clk,
  input  logic [7:0]       we,
  input  logic [AddrW-1:0] waddr,
  input  logic [63:0]      wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [63:0]      rdata
);

  logic [63:0] mem [1 << AddrW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sitcpxg_rx_buffer.sv
// SiTCP 10GbE receive buffer: byte-writable RAM drained as a valid/ready byte stream.
// Define SITCPXG_RXBUF_STATS_EN to add the STAT_RX_BYTES / STAT_MAX_OCC counters.
module sitcpxg_rx_buffer
  import sitcpxg_rx_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic        XGMII_CLOCK,
  input  logic        RSTs,
  output logic [15:0] USER_RX_SIZE,
  input  logic        USER_RX_CLR_ENB,
  output logic        USER_RX_CLR_REQ,
  output logic [15:0] USER_RX_RADR,
  input  logic [15:0] USER_RX_WADR,
  input  logic [7:0]  USER_RX_WENB,
  input  logic [63:0] USER_RX_WDAT,
  input  logic        FLUSH_REQ,
  output logic [63:0] M_DATA,
  output logic [3:0]  M_BYTES,
  output logic        M_VALID,
  input  logic        M_READY
`ifdef SITCPXG_RXBUF_STATS_EN
  ,
  output logic [31:0] STAT_RX_BYTES,
  output logic [15:0] STAT_MAX_OCC
`endif
);

  localparam int unsigned WordW  = ADDR_W - 3;
  localparam int unsigned RxSize = (1 << ADDR_W) - RXSIZE_MARGIN;

  clr_state_e state_q, state_d;
  logic clr_pulse, issue_ok;

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, avail, wr_end;
  logic [3:0]        seg_rem, seg;
  logic              wr_any, issue, push, pop;

  logic              inflight_q;
  logic [2:0]        off_q;
  logic [3:0]        seg_q;
  logic [63:0]       rd_word;

  rx_entry_t         fifo_q [2];
  rx_entry_t         push_entry, head;
  logic              fifo_wr_q, fifo_rd_q;
  logic [1:0]        fifo_cnt_q;

  logic              unused_wadr;

  assign USER_RX_SIZE = RxSize[15:0];
  assign USER_RX_RADR = 16'(rd_ptr_q);
  assign unused_wadr  = ^USER_RX_WADR;

  // Clear FSM: state register
  always_ff @(posedge XGMII_CLOCK or posedge RSTs) begin
    if (RSTs) state_q <= StRun;
    else      state_q <= state_d;
  end

  // Clear FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (FLUSH_REQ)       state_d = StClrWait;
      StClrWait:  if (USER_RX_CLR_ENB) state_d = StClrDrain;
      StClrDrain: if (!FLUSH_REQ)      state_d = StRun;
      default:                         state_d = StRun;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    clr_pulse = 1'b0;
    issue_ok  = 1'b0;
    unique case (state_q)
      StRun:     issue_ok  = !FLUSH_REQ;
      StClrWait: clr_pulse = USER_RX_CLR_ENB;
      default:   ;
    endcase
  end

  assign USER_RX_CLR_REQ = clr_pulse;

  assign wr_any = |USER_RX_WENB;
  assign wr_end = {USER_RX_WADR[ADDR_W-1:3], 3'b000} + ADDR_W'(end_offset(USER_RX_WENB));
  assign avail  = wr_ptr_q - rd_ptr_q;

  always_comb begin
    seg_rem = 4'(BYTES_PER_WORD) - {1'b0, rd_ptr_q[2:0]};
    seg     = (avail < ADDR_W'(seg_rem)) ? avail[3:0] : seg_rem;
  end

  // Never let queued plus in-flight beats exceed the two FIFO slots.
  assign issue = issue_ok && (avail != '0) &&
                 (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2);
  assign push  = inflight_q;
  assign pop   = (fifo_cnt_q != 2'd0) && M_READY;

  sitcpxg_rx_bram #(
    .AddrW (WordW)
  ) u_bram (
    .clk   (XGMII_CLOCK),
    .we    (USER_RX_WENB),
    .waddr (USER_RX_WADR[ADDR_W-1:3]),
    .wdata (USER_RX_WDAT),
    .re    (issue),
    .raddr (rd_ptr_q[ADDR_W-1:3]),
    .rdata (rd_word)
  );

  // Left-justify the segment and blank the bytes past its end.
  always_comb begin
    push_entry.data  = (rd_word << {off_q, 3'b000}) &
                       ~(64'hFFFF_FFFF_FFFF_FFFF >> {seg_q, 3'b000});
    push_entry.bytes = seg_q;
  end

  always_ff @(posedge XGMII_CLOCK or posedge RSTs) begin
    if (RSTs) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      off_q      <= 3'd0;
      seg_q      <= 4'd0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else if (clr_pulse) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (wr_any) wr_ptr_q <= wr_end;
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(seg);
        off_q    <= rd_ptr_q[2:0];
        seg_q    <= seg;
      end
      inflight_q <= issue;
      if (push) fifo_wr_q <= ~fifo_wr_q;
      if (pop)  fifo_rd_q <= ~fifo_rd_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge XGMII_CLOCK) begin
    if (push) fifo_q[fifo_wr_q] <= push_entry;
  end

  assign head    = fifo_q[fifo_rd_q];
  assign M_VALID = (fifo_cnt_q != 2'd0);
  assign M_DATA  = M_VALID ? head.data  : 64'd0;
  assign M_BYTES = M_VALID ? head.bytes : 4'd0;

`ifdef SITCPXG_RXBUF_STATS_EN
  logic [31:0] stat_bytes_q;
  logic [15:0] stat_occ_q;

  always_ff @(posedge XGMII_CLOCK or posedge RSTs) begin
    if (RSTs) begin
      stat_bytes_q <= 32'd0;
      stat_occ_q   <= 16'd0;
    end else if (clr_pulse) begin
      stat_bytes_q <= 32'd0;
      stat_occ_q   <= 16'd0;
    end else begin
      if (pop) stat_bytes_q <= stat_bytes_q + 32'(M_BYTES);
      if (16'(avail) > stat_occ_q) stat_occ_q <= 16'(avail);
    end
  end

  assign STAT_RX_BYTES = stat_bytes_q;
  assign STAT_MAX_OCC  = stat_occ_q;
`endif

endmodule

// File: tb/tb_sitcpxg_rx_buffer.sv
// Directed bench for sitcpxg_rx_buffer: a 64 KiB instance for stream/clear/reset
// cases and a 4 KiB instance for pointer wrap-around.
module tb_sitcpxg_rx_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_size, a_radr, a_wadr;
  logic        a_clr_enb, a_clr_req, a_flush, a_valid, a_ready;
  logic [7:0]  a_wenb;
  logic [63:0] a_wdat, a_data;
  logic [3:0]  a_bytes;

  logic [15:0] b_size, b_radr, b_wadr;
  logic        b_clr_enb, b_clr_req, b_flush, b_valid, b_ready;
  logic [7:0]  b_wenb;
  logic [63:0] b_wdat, b_data;
  logic [3:0]  b_bytes;

`ifdef SITCPXG_RXBUF_STATS_EN
  logic [31:0] a_stat_bytes, b_stat_bytes;
  logic [15:0] a_stat_occ, b_stat_occ;
`endif

  sitcpxg_rx_buffer #(.ADDR_W(16)) dut_a (
    .XGMII_CLOCK     (clk),
    .RSTs            (rst),
    .USER_RX_SIZE    (a_size),
    .USER_RX_CLR_ENB (a_clr_enb),
    .USER_RX_CLR_REQ (a_clr_req),
    .USER_RX_RADR    (a_radr),
    .USER_RX_WADR    (a_wadr),
    .USER_RX_WENB    (a_wenb),
    .USER_RX_WDAT    (a_wdat),
    .FLUSH_REQ       (a_flush),
    .M_DATA          (a_data),
    .M_BYTES         (a_bytes),
    .M_VALID         (a_valid),
    .M_READY         (a_ready)
`ifdef SITCPXG_RXBUF_STATS_EN
    ,
    .STAT_RX_BYTES   (a_stat_bytes),
    .STAT_MAX_OCC    (a_stat_occ)
`endif
  );

  sitcpxg_rx_buffer #(.ADDR_W(12)) dut_b (
    .XGMII_CLOCK     (clk),
    .RSTs            (rst),
    .USER_RX_SIZE    (b_size),
    .USER_RX_CLR_ENB (b_clr_enb),
    .USER_RX_CLR_REQ (b_clr_req),
    .USER_RX_RADR    (b_radr),
    .USER_RX_WADR    (b_wadr),
    .USER_RX_WENB    (b_wenb),
    .USER_RX_WDAT    (b_wdat),
    .FLUSH_REQ       (b_flush),
    .M_DATA          (b_data),
    .M_BYTES         (b_bytes),
    .M_VALID         (b_valid),
    .M_READY         (b_ready)
`ifdef SITCPXG_RXBUF_STATS_EN
    ,
    .STAT_RX_BYTES   (b_stat_bytes),
    .STAT_MAX_OCC    (b_stat_occ)
`endif
  );

  typedef struct {
    logic [15:0] wadr;
    logic [7:0]  wenb;
    logic [63:0] wdat;
    logic        ev;
    logic [3:0]  eb;
    logic [63:0] ed;
    logic [15:0] er;
  } vec_t;

  vec_t        vecs [11];
  logic [63:0] bp [4];
  int          n_vec = 0;
  int          n_err = 0;
  int          got;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // aligned word, then a 3+5 byte split of one word
    vecs[0]  = '{16'h0000, 8'hFF, 64'h0001020304050607, 1'b0, 4'd0, 64'd0, 16'h0000};
    vecs[1]  = '{16'h0000, 8'h00, 64'd0, 1'b0, 4'd0, 64'd0, 16'h0000};
    vecs[2]  = '{16'h0000, 8'h00, 64'd0, 1'b0, 4'd0, 64'd0, 16'h0008};
    vecs[3]  = '{16'h0000, 8'h00, 64'd0, 1'b1, 4'd8, 64'h0001020304050607, 16'h0008};
    vecs[4]  = '{16'h0000, 8'h00, 64'd0, 1'b0, 4'd0, 64'd0, 16'h0008};
    vecs[5]  = '{16'h0008, 8'hE0, 64'hAABBCC1234567890, 1'b0, 4'd0, 64'd0, 16'h0008};
    vecs[6]  = '{16'h0008, 8'h1F, 64'h999999DDEEFF0011, 1'b0, 4'd0, 64'd0, 16'h0008};
    vecs[7]  = '{16'h0000, 8'h00, 64'd0, 1'b0, 4'd0, 64'd0, 16'h000B};
    vecs[8]  = '{16'h0000, 8'h00, 64'd0, 1'b1, 4'd3, 64'hAABBCC0000000000, 16'h0010};
    vecs[9]  = '{16'h0000, 8'h00, 64'd0, 1'b1, 4'd5, 64'hDDEEFF0011000000, 16'h0010};
    vecs[10] = '{16'h0000, 8'h00, 64'd0, 1'b0, 4'd0, 64'd0, 16'h0010};
    bp[0] = 64'h1111111111111111;
    bp[1] = 64'h2222222222222222;
    bp[2] = 64'h3333333333333333;
    bp[3] = 64'h4444444444444444;

    rst = 1'b1;
    a_clr_enb = 1'b0; a_flush = 1'b0; a_ready = 1'b1;
    a_wadr = 16'd0; a_wenb = 8'd0; a_wdat = 64'd0;
    b_clr_enb = 1'b0; b_flush = 1'b0; b_ready = 1'b1;
    b_wadr = 16'd0; b_wenb = 8'd0; b_wdat = 64'd0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {a_valid, a_bytes, a_data, a_radr, a_clr_req}, '0);
    check("size_16", a_size, 16'hFFF0);
    check("size_12", b_size, 16'h0FF0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a_wadr = vecs[i].wadr;
      a_wenb = vecs[i].wenb;
      a_wdat = vecs[i].wdat;
      #1;
      check($sformatf("vec%0d", i), {a_valid, a_bytes, a_data, a_radr},
            {vecs[i].ev, vecs[i].eb, vecs[i].ed, vecs[i].er});
    end

    // Backpressure: two beats park in the FIFO, pointer stops 16 bytes on
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_ready = 1'b0;
      a_wadr  = 16'h0010 + 16'(8 * i);
      a_wenb  = 8'hFF;
      a_wdat  = bp[i];
    end
    @(negedge clk);
    a_wenb = 8'h00;
    repeat (10) @(negedge clk);
    #1;
    check("bp_stall_radr", a_radr, 16'h0020);
    check("bp_stall_head", {a_valid, a_bytes, a_data}, {1'b1, 4'd8, bp[0]});
    a_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (a_valid) begin
        check($sformatf("bp_beat%0d", got), {a_bytes, a_data}, {4'd8, bp[got]});
        got++;
      end
      @(negedge clk);
      #1;
    end
    check("bp_count", got, 4);
    check("bp_radr", a_radr, 16'h0030);

    // Clear handshake with data pending in RAM
    @(negedge clk);
    a_flush = 1'b1;
    a_ready = 1'b0;
    @(negedge clk);
    a_wadr = 16'h0030; a_wenb = 8'hFF; a_wdat = 64'hC0FFEE0012345678;
    @(negedge clk);
    a_wenb = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("clr_wait%0d", i), {a_clr_req, a_valid, a_radr}, {1'b0, 1'b0, 16'h0030});
    end
    @(negedge clk);
    a_clr_enb = 1'b1;
    #1;
    check("clr_pulse", a_clr_req, 1'b1);
    @(negedge clk);
    #1;
    check("clr_after", {a_clr_req, a_valid, a_radr}, '0);
    a_clr_enb = 1'b0;
    a_flush   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("clr_empty", {a_valid, a_radr}, '0);
    @(negedge clk);
    a_wadr = 16'h0000; a_wenb = 8'hFF; a_wdat = 64'h5A5A5A5A01020304;
    @(negedge clk);
    a_wenb  = 8'h00;
    a_ready = 1'b1;
    for (int c = 0; c < 10 && !a_valid; c++) begin
      @(negedge clk);
      #1;
    end
    check("clr_restart", {a_valid, a_bytes, a_data, a_radr},
          {1'b1, 4'd8, 64'h5A5A5A5A01020304, 16'h0008});

    // Asynchronous reset while a beat is presented
    @(negedge clk);
    a_ready = 1'b0;
    a_wadr = 16'h0008; a_wenb = 8'hFF; a_wdat = 64'h0BADF00D0BADF00D;
    @(negedge clk);
    a_wenb = 8'h00;
    for (int c = 0; c < 10 && !a_valid; c++) begin
      @(negedge clk);
      #1;
    end
    check("rst_pre_valid", a_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {a_valid, a_bytes, a_data, a_radr, a_clr_req}, '0);
    @(negedge clk);
    rst = 1'b0;
    a_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_idle", {a_valid, a_radr}, '0);

    // Wrap on the 4 KiB instance: park both pointers at 0xFF8 first
    @(negedge clk);
    b_wadr = 16'h0FF0; b_wenb = 8'h01; b_wdat = 64'd0;
    @(negedge clk);
    b_wenb = 8'h00;
    for (int c = 0; c < 4000 && !(b_radr == 16'h0FF8 && !b_valid); c++) begin
      @(negedge clk);
      #1;
    end
    repeat (5) @(negedge clk);
    #1;
    check("wrap_park", {b_valid, b_radr}, {1'b0, 16'h0FF8});
    @(negedge clk);
    b_wadr = 16'h0FF8; b_wenb = 8'hFF; b_wdat = 64'hA0A1A2A3A4A5A6A7;
    @(negedge clk);
    b_wadr = 16'h0000; b_wenb = 8'hFF; b_wdat = 64'hB0B1B2B3B4B5B6B7;
    @(negedge clk);
    b_wenb = 8'h00;
    #1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (b_valid) begin
        check($sformatf("wrap_beat%0d", got), {b_bytes, b_data},
              {4'd8, (got == 0) ? 64'hA0A1A2A3A4A5A6A7 : 64'hB0B1B2B3B4B5B6B7});
        got++;
      end
      @(negedge clk);
      #1;
    end
    check("wrap_count", got, 2);
    check("wrap_radr", b_radr, 16'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sitcpxg_rx_buffer.md
Name: sitcpxg_rx_buffer

Overview:
- Receive-side TCP buffer that sits directly downstream of the 10GbE SiTCP core's RX buffer-write interface.
- Owns a 64-bit-wide, byte-writable dual-port RAM. SiTCP writes received TCP payload into it through the WADR/WENB/WDAT signals (big-endian byte order).
- The block drains the RAM to user logic as a valid/ready byte stream and returns the read pointer (USER_RX_RADR) so SiTCP can compute its TCP window.
- Also handles the receive-buffer clear handshake.

Parameters:
- ADDR_W, 16, byte-address width of the buffer; legal range 12..16; capacity is 2^ADDR_W bytes, i.e. 2^(ADDR_W-3) words.

Ports:
- XGMII_CLOCK  in  1  156.25 MHz clock; the only clock.
- RSTs  in  1  reset, asynchronous, active-high.
- USER_RX_SIZE  out  16  buffer size reported to SiTCP = 2^ADDR_W - 16.
- USER_RX_CLR_ENB  in  1  from SiTCP: clear is permitted.
- USER_RX_CLR_REQ  out  1  to SiTCP: clear request, single-cycle pulse.
- USER_RX_RADR  out  16  read pointer in bytes; bits above ADDR_W are 0.
- USER_RX_WADR  in  16  write byte address; bits [ADDR_W-1:3] select the word.
- USER_RX_WENB  in  8  byte write enables; bit7 = byte offset 0 (big endian).
- USER_RX_WDAT  in  64  write data; [63:56] = byte offset 0.
- FLUSH_REQ  in  1  user request to discard all buffered data (level).
- M_DATA  out  64  output bytes, left-justified, [63:56] first.
- M_BYTES  out  4  valid byte count, 1..8.
- M_VALID  out  1  output valid.
- M_READY  in  1  output accept.

Behaviour:
- Reset values: USER_RX_RADR=0, USER_RX_CLR_REQ=0, M_VALID=0, M_BYTES=0, M_DATA=0. Internal wr_ptr=0, FIFO empty, state RUN.
- USER_RX_SIZE is constant: 2^ADDR_W - 16 (0xFFF0 when ADDR_W=16).
- Write port:
  - Any WENB bit set writes the enabled bytes of word WADR[ADDR_W-1:3] in the same cycle.
  - End byte = WADR[ADDR_W-1:3]*8 + (8 - index of the lowest set WENB bit).
  - wr_ptr is registered to the end byte one cycle later, modulo 2^ADDR_W.
  - WENB is assumed to hold a contiguous mask. A non-contiguous mask is still written, but wr_ptr uses the lowest set bit.
- Occupancy: avail = (wr_ptr - rd_ptr) mod 2^ADDR_W. avail==0 means empty. Full never occurs because SiTCP limits fill to USER_RX_SIZE.
- Read pipeline (rd_ptr drives USER_RX_RADR):
  - Issue condition: avail>0 and (FIFO occupancy + in-flight) < 2.
  - seg = min(8 - rd_ptr[2:0], avail).
  - On issue, a RAM read is started at word rd_ptr[ADDR_W-1:3], and rd_ptr += seg in the same cycle.
  - The RAM has 1-cycle read latency. Next cycle the word is shifted left by rd_ptr_old[2:0] bytes, the low bytes are zeroed, and the result is pushed with seg into a 2-entry output FIFO.
  - M_* is driven from the FIFO head; latency from issue to M_VALID is 2 cycles.
  - Peak throughput is 8 bytes/cycle when aligned.
- Read-pointer release: RADR advances at issue, not at handshake. This is safe because the bytes already sit in the FIFO.
- Read after write: a word is read no earlier than 1 cycle after its write because wr_ptr lags the write by 1 cycle, so the RAM needs no bypass.
- Partial words: a segment may end mid-word. Later writes into the same word are delivered from offset rd_ptr[2:0].
- Output handshake:
  - M_DATA, M_BYTES and M_VALID stay stable while M_VALID && !M_READY.
  - A pop and a push in the same cycle are allowed.
- Clear state machine (RUN -> CLR_WAIT -> CLR_DRAIN -> RUN):
  - RUN -> CLR_WAIT when FLUSH_REQ=1. Read issue stops immediately.
  - CLR_WAIT -> CLR_DRAIN on the first cycle with USER_RX_CLR_ENB=1. That cycle USER_RX_CLR_REQ=1 (one pulse), the FIFO and in-flight read are discarded, M_VALID drops, and rd_ptr=wr_ptr=0.
  - CLR_DRAIN -> RUN once FLUSH_REQ=0.
  - A write arriving in the clear cycle is dropped from wr_ptr tracking.
- Asynchronous reset mid-transfer returns every output and all internal state to the reset values.

Optional Feature:
- Macro: SITCPXG_RXBUF_STATS_EN.
- Defined:
  - Adds output STAT_RX_BYTES[31:0], which increments by M_BYTES on each M_VALID&&M_READY and wraps at 2^32.
  - Adds output STAT_MAX_OCC[15:0], a high-water mark of avail.
  - Both reset to 0 on RSTs and on the clear pulse.
- Undefined: the ports and logic are absent. Pointer, stream and clear behaviour are identical.

Decomposition:
- Package sitcpxg_rx_pkg holds:
  - constants BYTES_PER_WORD=8 and RXSIZE_MARGIN=16;
  - the clear-FSM state enum {RUN, CLR_WAIT, CLR_DRAIN};
  - the FIFO-entry struct {data[63:0], bytes[3:0]}.
- One sub-module, sitcpxg_rx_bram: simple dual-port RAM, 64-bit data, 8 byte enables, registered read.
- The FIFO, pointer logic and FSM stay in the top module.

Test Plan:
- Aligned write: WADR=0x0000, WENB=0xFF, WDAT=0x0001020304050607 -> after 3 cycles M_DATA=0x0001020304050607, M_BYTES=8; USER_RX_RADR=8.
- Unaligned: write WADR=0x0008, WENB=0xE0 (3 bytes AA BB CC), then WADR=0x0008, WENB=0x1F (DD..11) -> two beats: M_BYTES=3, M_DATA=0xAABBCC0000000000, then M_BYTES=5 starting 0xDD; RADR=0x10.
- Backpressure: 4 words written with M_READY=0 -> FIFO holds 2, RADR stops at 16; raise M_READY -> 4 beats in order, RADR=32.
- Wrap (ADDR_W=12): rd_ptr=wr_ptr=0xFF8; write 16 bytes across the wrap -> beats at word 0x1FF then word 0; RADR=0x008; USER_RX_SIZE=0x0FF0.
- Clear: data pending, FLUSH_REQ=1, CLR_ENB=0 for 5 cycles then 1 -> no issues while waiting; exactly one CLR_REQ pulse; M_VALID=0; RADR=0.
- Reset mid-stream: assert RSTs while M_VALID=1 -> all outputs reach reset values immediately, without waiting for a clock edge.
